spi_fifo_seq: RTL and testbench
===============================

SPI_FIFO_SEQ -- requirements
Module: spi_fifo_seq

Interface
REQ-001 Parameter WIDTH, default 8: SPI word size in bits, equal to the data width of the attached TX/RX FIFOs.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal values are 2 or more.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 enable  in  1  permits new word transfers to start.
REQ-006 tx_data  in  WIDTH  TX FIFO head word, valid while tx_exists=1.
REQ-007 tx_exists  in  1  TX FIFO not-empty flag.
REQ-008 tx_read  out  1  one-cycle pop strobe to the TX FIFO.
REQ-009 rx_data  out  WIDTH  received word presented to the RX FIFO.
REQ-010 rx_write  out  1  one-cycle push strobe to the RX FIFO.
REQ-011 rx_full  in  1  RX FIFO full flag.
REQ-012 sck, mosi, cs_n  out  1 each  SPI mode-0 master pins.
REQ-013 miso  in  1  SPI data from the slave.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 overflow  out  1  sticky flag: a received word was dropped.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, SHIFT and STORE.
REQ-017 IDLE->LOAD SHALL occur when enable=1, tx_exists=1 and the start condition of REQ-030 is met.
REQ-018 In LOAD (one cycle): tx_read=1, tx_data is captured into the TX shift register, cs_n is driven 0, the bit counter and divider are cleared, and the FSM goes to SHIFT.
REQ-019 In SHIFT: mosi = TX shift register MSB, MSB first; a divider tick occurs every CLK_DIV cycles.
REQ-020 On a tick with sck=0: sck goes to 1 and miso is shifted into the LSB of the RX shift register.
REQ-021 On a tick with sck=1: sck goes to 0, the TX shift register shifts left, and the bit counter increments; if the bit counter equals WIDTH-1, the FSM goes to STORE.
REQ-022 Each word SHALL occupy exactly 2*WIDTH*CLK_DIV cycles in SHIFT; sck SHALL end low.
REQ-023 In STORE (one cycle): rx_data = RX shift register; rx_write=1 unless rx_full=1.
REQ-024 If rx_full=1 in STORE, rx_write SHALL stay 0 and overflow SHALL be set to 1.
REQ-025 From STORE: if enable=1, tx_exists=1 and the start condition is met, go to LOAD with cs_n held 0 (back-to-back); otherwise go to IDLE with cs_n=1.
REQ-026 Deasserting enable mid-word SHALL NOT abort the word; it only blocks the next start.
REQ-027 tx_read and rx_write SHALL never be high outside LOAD and STORE respectively.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 On rst=1 at a clk edge, from any state including mid-word: state=IDLE, sck=0, cs_n=1, mosi=0, tx_read=0, rx_write=0, rx_data=0, overflow=0, busy=0, and the counters and shift registers are cleared; a partial word is discarded.

Configuration
REQ-030 Macro SPI_FIFO_SEQ_RX_STALL_EN:
- Defined: the start condition additionally requires rx_full=0, so overflow can never set.
- Undefined: the start condition ignores rx_full, and REQ-024 applies.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the default WIDTH and CLK_DIV constants.
REQ-032 Sub-module spi_sck_div SHALL generate the divider tick (clear input, tick output, CLK_DIV parameter); all other logic stays in spi_fifo_seq.

Verification
REQ-033 WIDTH=8, CLK_DIV=2, one TX word 0xA5, miso looped to mosi -> mosi bit pattern 1,0,1,0,0,1,0,1; rx_write pulses once with rx_data=0xA5; cs_n low for 1+32+1 cycles.
REQ-034 Three queued TX words with enable=1 -> cs_n stays low throughout; exactly three tx_read and three rx_write pulses, each exactly one cycle wide.
REQ-035 miso tied to 1, rx_full=1 held, macro undefined -> no rx_write pulse; overflow=1 after STORE and remains 1.
REQ-036 Same stimulus as REQ-035 with the macro defined -> FSM stays in IDLE, tx_read never pulses; after rx_full falls, the transfer starts within 1 cycle.
REQ-037 rst asserted at bit 4 of a word -> next cycle cs_n=1, sck=0, busy=0, no rx_write; the following transfer completes correctly.
REQ-038 enable dropped during bit 2 -> current word completes with one rx_write, then IDLE with cs_n=1 despite tx_exists=1.

Source files
------------

// File: rtl/spi_fifo_seq_pkg.sv
// Shared types and default sizing for the SPI FIFO sequencer.
package spi_fifo_seq_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_CLK_DIV = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_STORE = 2'd3
   } state_t;

endpackage

// File: rtl/spi_fifo_seq_sck_div.sv
// SCK half-period divider: down-counter that ticks once every CLK_DIV clk cycles while not cleared.
module spi_sck_div
   import spi_fifo_seq_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

   logic [DW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= RELOAD;
      end else if (cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - DW'(1);
      end
   end

   assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/spi_fifo_seq.sv
// SPI mode-0 master moving words from a TX FIFO to an RX FIFO.
// Optional macro SPI_FIFO_SEQ_RX_STALL_EN: hold off new words while the RX FIFO is full.
//
// state    | meaning
// ST_IDLE  | cs_n high, waiting for enable and a TX word
// ST_LOAD  | pop TX FIFO, capture word, cs_n low
// ST_SHIFT | clock out/in WIDTH bits on sck
// ST_STORE | push received word (or flag overflow when RX is full)
module spi_fifo_seq
   import spi_fifo_seq_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_exists,
   output logic             tx_read,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_write,
   input  logic             rx_full,
   output logic             sck,
   output logic             mosi,
   output logic             cs_n,
   input  logic             miso,
   output logic             busy,
   output logic             overflow
);

   localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic [BW-1:0]    bit_cnt;
   logic             sck_q;
   logic             overflow_q;
   logic             tick;
   logic             start_ok;

`ifdef SPI_FIFO_SEQ_RX_STALL_EN
   assign start_ok = enable & tx_exists & ~rx_full;
`else
   assign start_ok = enable & tx_exists;
`endif

   spi_sck_div #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_div (
      .clk   (clk),
      .rst   (rst),
      .clear (state != ST_SHIFT),
      .tick  (tick)
   );

   always_comb begin
      state_nxt = state;
      tx_read   = 1'b0;
      rx_write  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            tx_read   = 1'b1;
            state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (tick && sck_q && (bit_cnt == LAST_BIT)) state_nxt = ST_STORE;
         end
         ST_STORE: begin
            rx_write  = ~rx_full;
            state_nxt = start_ok ? ST_LOAD : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
         sck_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_LOAD: begin
               tx_sr   <= tx_data;
               bit_cnt <= '0;
               sck_q   <= 1'b0;
            end
            ST_SHIFT: begin
               // rising sck samples miso, falling sck advances mosi
               if (tick && !sck_q) begin
                  sck_q <= 1'b1;
                  rx_sr <= {rx_sr[WIDTH-2:0], miso};
               end else if (tick) begin
                  sck_q   <= 1'b0;
                  tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
                  bit_cnt <= bit_cnt + BW'(1);
               end
            end
            ST_STORE: begin
               if (rx_full) overflow_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sck      = sck_q;
   assign mosi     = (state == ST_SHIFT) & tx_sr[WIDTH-1];
   assign cs_n     = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign rx_data  = rx_sr;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_fifo_seq.sv
// Bench for spi_fifo_seq: queue-based FIFO models, loopback slave, word-level expectations.
module tb_spi_fifo_seq;

   localparam int W        = 8;
   localparam int DIV      = 2;
   localparam int WORD_CYC = 2 + 2 * W * DIV;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         tx_exists = 1'b0;
   logic         tx_read;
   logic [W-1:0] rx_data;
   logic         rx_write;
   logic         rx_full = 1'b0;
   logic         sck, mosi, cs_n, miso, busy, overflow;
   logic [1:0]   miso_mode = 2'd0;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] txq[$];
   logic [W-1:0] rx_log [0:255];
   int           cs_log [0:63];
   int           rx_cnt = 0, tx_rd_cnt = 0, cs_cnt = 0, cs_run = 0, wide_err = 0, word_bits = 0;
   logic [W-1:0] mosi_sr = '0;
   logic         prev_sck = 1'b0, prev_txr = 1'b0, prev_rxw = 1'b0;
   int           rd_ptr = 0;

   always #5 clk = ~clk;

   // slave model: loopback, inverted loopback, or tied high
   assign miso = (miso_mode == 2'd2) ? 1'b1 : ((miso_mode == 2'd1) ? ~mosi : mosi);

   spi_fifo_seq #(.WIDTH(W), .CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_exists(tx_exists),
      .tx_read(tx_read), .rx_data(rx_data), .rx_write(rx_write), .rx_full(rx_full),
      .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso), .busy(busy), .overflow(overflow)
   );

   // monitor and TX FIFO model: sample at negedge, pop just after the edge that ends LOAD
   always begin
      logic pop;
      @(negedge clk);
      if (tx_read) begin tx_rd_cnt++; word_bits = 0; end
      if (tx_read && prev_txr) wide_err++;
      if (rx_write && prev_rxw) wide_err++;
      if (rx_write) begin rx_log[rx_cnt[7:0]] = rx_data; rx_cnt++; end
      if (sck && !prev_sck) begin mosi_sr = {mosi_sr[W-2:0], mosi}; word_bits++; end
      if (!cs_n) cs_run++;
      else if (cs_run > 0) begin cs_log[cs_cnt[5:0]] = cs_run; cs_cnt++; cs_run = 0; end
      prev_sck = sck; prev_txr = tx_read; prev_rxw = rx_write;
      pop = tx_read;
      @(posedge clk);
      #1;
      if (pop && txq.size() > 0) void'(txq.pop_front());
      tx_exists = (txq.size() != 0);
      tx_data   = tx_exists ? txq[0] : '0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] w);
      txq.push_back(w);
   endtask

   task automatic expect_rx(input logic [W-1:0] w);
      chk("rx_data", {24'd0, rx_log[rd_ptr[7:0]]}, {24'd0, w});
      rd_ptr++;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      repeat (3) @(negedge clk);
      while (busy && n < max) begin @(negedge clk); n++; end
      chk("idle_reached", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_bits(input int nb, input int rd0);
      int n;
      n = 0;
      while (!(tx_rd_cnt > rd0 && word_bits == nb) && n < 400) begin @(negedge clk); n++; end
      chk("bit_reached", word_bits, nb);
   endtask

   initial begin
      int rx0, tx0, cs0, n;
      logic inv;
      logic [W-1:0] w, w2, words[$];

      repeat (3) @(negedge clk);
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_sck", {31'd0, sck}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_strobes", {30'd0, tx_read, rx_write}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // single word 0xA5 in loopback
      rx0 = rx_cnt; tx0 = tx_rd_cnt;
      push(8'hA5); enable = 1'b1;
      wait_idle(100); enable = 1'b0;
      chk("a5_mosi_bits", {24'd0, mosi_sr}, 32'hA5);
      chk("a5_rx_count", rx_cnt - rx0, 1);
      expect_rx(8'hA5);
      chk("a5_cs_low", cs_log[cs_cnt-1], WORD_CYC);
      chk("a5_tx_reads", tx_rd_cnt - tx0, 1);

      // three queued words back to back
      rx0 = rx_cnt; tx0 = tx_rd_cnt; cs0 = cs_cnt; words = {};
      for (int i = 0; i < 3; i++) begin w = W'($urandom); words.push_back(w); push(w); end
      enable = 1'b1;
      wait_idle(300); enable = 1'b0;
      chk("b2b_rx_count", rx_cnt - rx0, 3);
      chk("b2b_tx_reads", tx_rd_cnt - tx0, 3);
      chk("b2b_cs_runs", cs_cnt - cs0, 1);
      chk("b2b_cs_low", cs_log[cs_cnt-1], 3 * WORD_CYC);
      chk("b2b_pulse_width", wide_err, 0);
      foreach (words[i]) expect_rx(words[i]);

      // random bursts, plain or inverted slave
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 3);
         inv = 1'($urandom_range(0, 1));
         miso_mode = inv ? 2'd1 : 2'd0;
         rx0 = rx_cnt; words = {};
         for (int i = 0; i < n; i++) begin w = W'($urandom); words.push_back(w); push(w); end
         enable = 1'b1;
         wait_idle(n * WORD_CYC + 40); enable = 1'b0;
         chk("rnd_rx_count", rx_cnt - rx0, n);
         chk("rnd_cs_low", cs_log[cs_cnt-1], n * WORD_CYC);
         foreach (words[i]) expect_rx(inv ? ~words[i] : words[i]);
      end

      // RX FIFO full
      miso_mode = 2'd2; rx_full = 1'b1;
      rx0 = rx_cnt; tx0 = tx_rd_cnt;
      push(W'($urandom)); enable = 1'b1;
`ifdef SPI_FIFO_SEQ_RX_STALL_EN
      repeat (20) @(negedge clk);
      chk("stall_no_read", tx_rd_cnt - tx0, 0);
      chk("stall_idle", {31'd0, busy}, 32'd0);
      rx_full = 1'b0;
      @(negedge clk);
      chk("stall_start", {31'd0, tx_read}, 32'd1);
      wait_idle(100); enable = 1'b0;
      chk("stall_rx_count", rx_cnt - rx0, 1);
      expect_rx('1);
      chk("stall_no_ovf", {31'd0, overflow}, 32'd0);
`else
      wait_idle(100); enable = 1'b0;
      chk("ovf_no_write", rx_cnt - rx0, 0);
      chk("ovf_tx_reads", tx_rd_cnt - tx0, 1);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      repeat (20) @(negedge clk);
      rx_full = 1'b0;
      repeat (5) @(negedge clk);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
`endif
      rx_full = 1'b0;

      // reset in the middle of a word
      miso_mode = 2'd0;
      rx0 = rx_cnt; tx0 = tx_rd_cnt;
      push(W'($urandom)); enable = 1'b1;
      wait_bits(4, tx0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("mrst_sck", {31'd0, sck}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_ovf", {31'd0, overflow}, 32'd0);
      chk("mrst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("mrst_mosi", {31'd0, mosi}, 32'd0);
      rst = 1'b0; enable = 1'b0;
      repeat (10) @(negedge clk);
      chk("mrst_no_write", rx_cnt - rx0, 0);
      w2 = W'($urandom);
      push(w2); enable = 1'b1;
      wait_idle(100); enable = 1'b0;
      chk("mrst_next_count", rx_cnt - rx0, 1);
      expect_rx(w2);
      chk("mrst_next_cs_low", cs_log[cs_cnt-1], WORD_CYC);

      // enable dropped mid-word
      rx0 = rx_cnt; tx0 = tx_rd_cnt;
      w = W'($urandom); w2 = W'($urandom);
      push(w); push(w2); enable = 1'b1;
      wait_bits(2, tx0);
      enable = 1'b0;
      wait_idle(100);
      chk("endrop_rx_count", rx_cnt - rx0, 1);
      expect_rx(w);
      chk("endrop_cs_n", {31'd0, cs_n}, 32'd1);
      chk("endrop_tx_exists", {31'd0, tx_exists}, 32'd1);
      repeat (20) @(negedge clk);
      chk("endrop_tx_reads", tx_rd_cnt - tx0, 1);
      enable = 1'b1;
      wait_idle(100); enable = 1'b0;
      expect_rx(w2);
      chk("final_pulse_width", wide_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
